// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the immediate-format select codes (SEXT_op_*), the RV32 major opcodes the predecoder
// recognises, and the fetch FSM state type.
package fetch_stage_pkg;

  localparam int unsigned SextW = 3;

  // Immediate-format select codes driven to the sign-extension unit; none must stay 0.
  localparam logic [SextW-1:0] SEXT_op_NONE = 3'd0;
  localparam logic [SextW-1:0] SEXT_op_I    = 3'd1;
  localparam logic [SextW-1:0] SEXT_op_S    = 3'd2;
  localparam logic [SextW-1:0] SEXT_op_B    = 3'd3;
  localparam logic [SextW-1:0] SEXT_op_U    = 3'd4;
  localparam logic [SextW-1:0] SEXT_op_J    = 3'd5;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's handshake signals.
//   imem_req_*/imem_addr : request to instruction memory (fetch -> memory)
//   imem_rsp_*           : response from instruction memory
//   redirect_*           : branch/jump redirect strobe and target
//   id_*                 : IF/ID register presented to decode, with id_ready back-pressure
// master = fetch stage side, slave = memory/decode/redirect side.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [31:0]      imem_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_pc;
  logic [31:0]      id_pc4;
  logic [31:0]      id_inst;
  logic [SextW-1:0] id_sext_op;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_pc, id_pc4, id_inst, id_sext_op,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_pc, id_pc4, id_inst, id_sext_op,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_predecode.sv
// Combinational opcode predecoder: maps opcode[6:0] to the immediate-format select code.
//   opcode_i  : instruction bits [6:0]
//   sext_op_o : SEXT_op_* code (SEXT_op_NONE for formats without an immediate)
// Kept standalone so decode can reuse it.
module fetch_predecode
  import fetch_stage_pkg::*;
(
  input  logic [6:0]       opcode_i,
  output logic [SextW-1:0] sext_op_o
);

  always_comb begin
    sext_op_o = SEXT_op_NONE;
    case (opcode_i)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: sext_op_o = SEXT_op_I;
      OPC_STORE:                      sext_op_o = SEXT_op_S;
      OPC_BRANCH:                     sext_op_o = SEXT_op_B;
      OPC_LUI, OPC_AUIPC:             sext_op_o = SEXT_op_U;
      OPC_JAL:                        sext_op_o = SEXT_op_J;
      default:                        sext_op_o = SEXT_op_NONE;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to instruction memory,
// and holds the result in a single-entry IF/ID register with a predecoded immediate format.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fetch_stage_if.master (imem request/response, redirect, IF/ID outputs)
// Redirects flush IF/ID and, if a request is in flight, mark its response to be dropped.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             drop_q, drop_d;
  logic             id_valid_q, id_valid_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic [31:0]      id_pc4_q, id_pc4_d;
  logic [31:0]      id_inst_q, id_inst_d;
  logic [SextW-1:0] id_sext_op_q, id_sext_op_d;

  logic [SextW-1:0] rsp_sext_op;
  logic [31:0]      pc_plus4;
  logic             req_valid, req_fire, rsp_fire, load;
  logic             unused_redirect_lsbs;

  fetch_predecode u_predecode (
    .opcode_i  (bus.imem_rsp_data[6:0]),
    .sext_op_o (rsp_sext_op)
  );

  assign pc_plus4  = pc_q + 32'd4;
  // Only request when the IF/ID slot will be free to take the response.
  assign req_valid = (state_q == StReq) && (!id_valid_q || bus.id_ready);
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign rsp_fire  = (state_q == StWait) && bus.imem_rsp_valid;
  // A response landing with a redirect belongs to the old path and is never loaded.
  assign load      = rsp_fire && !drop_q && !bus.redirect_valid;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    id_inst_d    = id_inst_q;
    id_sext_op_d = id_sext_op_q;

    if (id_valid_q && bus.id_ready) begin
      id_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (req_fire) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (rsp_fire) begin
          state_d = StReq;
          drop_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      id_valid_d   = 1'b1;
      id_pc_d      = pc_q;
      id_pc4_d     = pc_plus4;
      id_inst_d    = bus.imem_rsp_data;
      id_sext_op_d = rsp_sext_op;
      pc_d         = pc_plus4;
    end

    if (bus.redirect_valid) begin
      pc_d       = {bus.redirect_pc[31:2], 2'b00};
      id_valid_d = 1'b0;
      // Still owed a response after this edge: wait for it and throw it away.
      if ((state_q == StWait && !rsp_fire) || req_fire) begin
        drop_d  = 1'b1;
        state_d = StWait;
      end else begin
        drop_d  = 1'b0;
        state_d = StReq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= 32'h0;
      id_pc4_q     <= 32'h0;
      id_inst_q    <= 32'h0;
      id_sext_op_q <= SEXT_op_NONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      id_inst_q    <= id_inst_d;
      id_sext_op_q <= id_sext_op_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.id_valid       = id_valid_q;
  assign bus.id_pc          = id_pc_q;
  assign bus.id_pc4         = id_pc4_q;
  assign bus.id_inst        = id_inst_q;
  assign bus.id_sext_op     = id_sext_op_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a small instruction memory model with programmable
// response latency, a table of predecode vectors, and directed sequences for reset,
// back-pressure, redirects and PC wrap.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  sext;
  } vec_t;

  logic [31:0] img [16];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:6] == 26'h8) return img[a[5:2]];
    if (a == 32'h0000_0300) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: one outstanding read, response rsp_delay cycles after the handshake edge.
  int unsigned rsp_delay = 1;
  logic        mem_pend  = 1'b0;
  int unsigned mem_cnt   = 0;
  logic [31:0] mem_addr  = 32'h0;
  always begin : mem_model
    logic        hs;
    logic        rst_lo;
    logic [31:0] a;
    @(negedge clk);
    hs     = bus.imem_req_valid && bus.imem_req_ready;
    a      = bus.imem_addr;
    rst_lo = !rst_n;
    @(posedge clk);
    #1;
    bus.imem_rsp_valid = 1'b0;
    if (rst_lo) begin
      mem_pend = 1'b0;
    end else begin
      if (hs) begin
        mem_pend = 1'b1;
        mem_addr = a;
        mem_cnt  = rsp_delay;
      end
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(mem_addr);
          mem_pend           = 1'b0;
        end
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [31:0] target);
    drive_edge();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    drive_edge();
    bus.redirect_valid = 1'b0;
  endtask

  // Advance to the next negedge at which id_valid is high.
  task automatic wait_id(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.id_valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Check the current sample first, then advance negedge by negedge.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.imem_req_valid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_id_valid"}, 32'(bus.id_valid), 32'h0);
    check({tag, "_id_pc"}, bus.id_pc, 32'h0);
    check({tag, "_id_pc4"}, bus.id_pc4, 32'h0);
    check({tag, "_id_inst"}, bus.id_inst, 32'h0);
    check({tag, "_id_sext"}, 32'(bus.id_sext_op), 32'(SEXT_op_NONE));
    check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'h0);
    check({tag, "_addr"}, bus.imem_addr, 32'h0);
  endtask

  vec_t vecs [10];

  initial begin
    bit ok;
    bit saw;
    int prev_cyc;

    vecs[0] = '{32'h0050_0093, SEXT_op_I};
    vecs[1] = '{32'h0011_2023, SEXT_op_S};
    vecs[2] = '{32'hFE00_0EE3, SEXT_op_B};
    vecs[3] = '{32'h0000_12B7, SEXT_op_U};
    vecs[4] = '{32'h0080_006F, SEXT_op_J};
    vecs[5] = '{32'h0000_0000, SEXT_op_NONE};
    vecs[6] = '{32'h0000_8067, SEXT_op_I};
    vecs[7] = '{32'h0000_2083, SEXT_op_I};
    vecs[8] = '{32'h0000_0097, SEXT_op_U};
    vecs[9] = '{32'h0000_0033, SEXT_op_NONE};
    for (int i = 0; i < 16; i++) img[i] = 32'h0;

    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;

    // Reset state, then one quiet cycle and the first request on cycle 2.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    drive_edge();
    rst_n = 1'b1;
    @(negedge clk);
    check("quiet_cycle_req", 32'(bus.imem_req_valid), 32'h0);
    @(negedge clk);
    check("first_req_valid", 32'(bus.imem_req_valid), 32'h1);
    check("first_req_addr", bus.imem_addr, 32'h0);

    // Streaming: one instruction every 2 cycles.
    prev_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      wait_id(ok);
      check("stream_id_seen", 32'(ok), 32'h1);
      check("stream_id_pc", bus.id_pc, 32'(4 * k));
      check("stream_id_pc4", bus.id_pc4, 32'(4 * k + 4));
      check("stream_id_inst", bus.id_inst, mem_word(32'(4 * k)));
      if (k > 0) check("stream_spacing", 32'(cyc - prev_cyc), 32'd2);
      prev_cyc = cyc;
    end

    // Back-pressure: held instruction at 0xC, no new requests, release restarts same cycle.
    drive_edge();
    bus.id_ready = 1'b0;
    wait_id(ok);
    check("stall_id_seen", 32'(ok), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_no_req", 32'(bus.imem_req_valid), 32'h0);
      check("stall_id_valid", 32'(bus.id_valid), 32'h1);
      check("stall_id_pc", bus.id_pc, 32'h0000_000C);
      check("stall_id_inst", bus.id_inst, mem_word(32'h0000_000C));
    end
    drive_edge();
    bus.id_ready = 1'b1;
    @(negedge clk);
    check("release_req_valid", 32'(bus.imem_req_valid), 32'h1);
    check("release_req_addr", bus.imem_addr, 32'h0000_0010);

    // Redirect while in WAIT; the stale response arrives later and must be dropped.
    rsp_delay = 3;
    redirect(32'h0000_0300);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = bus.imem_req_valid && bus.imem_addr == 32'h0000_0300;
    end
    check("stale_setup_req", 32'(ok), 32'h1);
    redirect(32'h0000_1003);
    saw = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.id_valid) saw = 1'b1;
      ok = bus.imem_req_valid;
    end
    check("stale_req_seen", 32'(ok), 32'h1);
    check("stale_dropped", 32'(saw), 32'h0);
    check("stale_next_addr", bus.imem_addr, 32'h0000_1000);
    wait_id(ok);
    check("stale_id_seen", 32'(ok), 32'h1);
    check("stale_id_pc", bus.id_pc, 32'h0000_1000);
    check("stale_id_inst", bus.id_inst, mem_word(32'h0000_1000));

    // Redirect on the same edge as a response.
    rsp_delay = 1;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      drive_edge();
      ok = bus.imem_rsp_valid;
    end
    check("same_edge_rsp_seen", 32'(ok), 32'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0500;
    drive_edge();
    bus.redirect_valid = 1'b0;
    saw = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.id_valid) saw = 1'b1;
      ok = bus.imem_req_valid;
    end
    check("same_edge_req_seen", 32'(ok), 32'h1);
    check("same_edge_discarded", 32'(saw), 32'h0);
    check("same_edge_next_addr", bus.imem_addr, 32'h0000_0500);
    wait_id(ok);
    check("same_edge_id_seen", 32'(ok), 32'h1);
    check("same_edge_id_pc", bus.id_pc, 32'h0000_0500);

    // Predecode vectors fetched from 0x200.
    for (int i = 0; i < 10; i++) img[i] = vecs[i].inst;
    redirect(32'h0000_0200);
    for (int i = 0; i < 10; i++) begin
      wait_id(ok);
      check("pd_id_seen", 32'(ok), 32'h1);
      check("pd_id_pc", bus.id_pc, 32'h0000_0200 + 32'(4 * i));
      check("pd_id_inst", bus.id_inst, vecs[i].inst);
      check("pd_sext_op", 32'(bus.id_sext_op), 32'(vecs[i].sext));
    end

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFFC);
    wait_id(ok);
    check("wrap_id_seen", 32'(ok), 32'h1);
    check("wrap_id_pc", bus.id_pc, 32'hFFFF_FFFC);
    check("wrap_id_pc4", bus.id_pc4, 32'h0000_0000);
    check("wrap_next_req", 32'(bus.imem_req_valid), 32'h1);
    check("wrap_next_addr", bus.imem_addr, 32'h0000_0000);

    // Reset asserted while a request is outstanding.
    rsp_delay = 3;
    wait_req(ok);
    check("rst_setup_req", 32'(ok), 32'h1);
    drive_edge();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    rsp_delay = 1;
    drive_edge();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_quiet_req", 32'(bus.imem_req_valid), 32'h0);
    @(negedge clk);
    check("midrst_first_req", 32'(bus.imem_req_valid), 32'h1);
    check("midrst_first_addr", bus.imem_addr, 32'h0);
    wait_id(ok);
    check("midrst_id_seen", 32'(ok), 32'h1);
    check("midrst_id_pc", bus.id_pc, 32'h0);
    check("midrst_id_inst", bus.id_inst, mem_word(32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that owns the PC and issues word reads to instruction memory over a valid/ready request and response interface.
- Holds the fetched instruction in a single-entry IF/ID output register and presents it to decode with a valid/ready handshake.
- Predecodes the opcode into the immediate-format select code, so decode can drive the sign-extension unit directly from registered bits.
- Handles redirects from branch/jump resolution, including discarding an in-flight stale response.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  fetched instruction.
- redirect_valid  in  1  one-cycle redirect strobe.
- redirect_pc  in  32  redirect target; bits [1:0] treated as 0.
- id_valid  out  1  IF/ID register holds an instruction.
- id_ready  in  1  decode consumes this cycle.
- id_pc  out  32  PC of the held instruction.
- id_pc4  out  32  id_pc + 4.
- id_inst  out  32  held instruction word.
- id_sext_op  out  3  predecoded immediate format: I/S/B/U/J/none.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, pc=RESET_PC, drop=0.
  - id_valid=0, id_pc=0, id_pc4=0, id_inst=0, id_sext_op=none.
  - imem_req_valid=0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ unconditionally on the next cycle. Guarantees one quiet cycle after reset.
  - REQ: imem_req_valid=1 only when the output register is free, i.e. !id_valid || id_ready. imem_addr=pc. Handshake completes when imem_req_valid && imem_req_ready; then -> WAIT.
  - WAIT: imem_req_valid=0. At most one request is outstanding. On imem_rsp_valid:
    - if drop=1: discard the data, clear drop, -> REQ.
    - else: load id_inst=data, id_pc=pc, id_pc4=pc+4, id_sext_op=predecode(data[6:0]), set id_valid=1, set pc=pc+4, -> REQ.
  - imem_rsp_valid in IDLE or REQ is ignored.
- Output register:
  - id_valid clears on id_valid && id_ready unless a new load happens the same cycle; a load wins.
  - Outputs are stable while id_valid && !id_ready.
  - Peak throughput is 1 instruction per 2 cycles with zero-latency memory.
- Redirect (redirect_valid=1), applied at that edge and highest priority:
  - pc = {redirect_pc[31:2],2'b00}.
  - id_valid=0 (flush).
  - If in WAIT, or in REQ with the handshake completing this same cycle: set drop=1 and go to / stay in WAIT.
  - Otherwise go to REQ.
  - A response arriving the same cycle as a redirect is discarded and does not clear drop if still pending. If that response completes the pending request, drop clears and the state goes to REQ.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Predecode of opcode[6:0]:
  - 0010011, 0000011, 1100111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - anything else -> none
- Reset mid-operation: the synchronous reset overrides everything, including a pending response and redirect. Instruction memory is reset by the same rst_n.

Decomposition:
- The SEXT_op_* codes live in the shared defines header (include file defines.vh), including a none code, with the value 0 for none. Add the opcode constants (OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL) there as well.
- One combinational sub-module: fetch_predecode (opcode[6:0] -> sext_op[2:0]). It is reusable by decode.

Test Plan:
- Reset release, memory always ready, 1-cycle response, id_ready=1 -> first imem_addr=0x0000_0000 on cycle 2; id_pc sequence 0x0, 0x4, 0x8 every 2 cycles; id_pc4 = id_pc+4.
- id_ready=0 with id_valid=1 for 5 cycles -> no new imem_req_valid; id_inst/id_pc stable. Release -> next request the same cycle id_ready rises.
- Redirect to 0x0000_1003 while in WAIT; the stale response (0xDEADBEEF) arrives 3 cycles later -> response discarded, id_valid stays 0; next imem_addr=0x0000_1000.
- Redirect on the same edge as imem_rsp_valid -> that data is not presented; next fetch comes from the redirect target.
- Fetch words 0x00500093, 0x00112023, 0xFE000EE3, 0x000012B7, 0x0080006F, 0x00000000 -> id_sext_op = I, S, B, U, J, none.
- Redirect to 0xFFFF_FFFC -> id_pc=0xFFFF_FFFC, id_pc4=0x0000_0000, next fetch 0x0000_0000. Assert rst_n=0 while in WAIT -> all outputs 0 next edge; after release, fetch restarts at RESET_PC.
